// File: rtl/fetch_top.sv
// fetch_top: instruction fetch stage, producer side of the IF/ID boundary.
//
// Holds the PC, issues instruction-memory reads over a req/ack handshake of
// variable latency and loads {pc+4, instruction} into the IF/ID registers.
// Decode may stall (hazard_stall) or redirect (is_jump/jump_addr), and the
// M stage may redirect (branch_taken/branch_addr). A branch outranks a jump
// and takes effect even while decode is stalled. A NOP bubble is loaded
// whenever no valid instruction is available.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   hazard_stall               hold IF/ID and PC
//   is_jump, jump_addr         decode redirect
//   branch_taken, branch_addr  M-stage redirect (highest priority)
//   imem_req, imem_addr        memory read request (driven from registers)
//   imem_ack, imem_data        memory data valid pulse and read data
//   pc, instruction            IF/ID registers
//
// Optional build macro FETCH_PERF_EN adds perf_fetched, perf_bubbles and
// perf_squashed counters (32 bit, wrap silently).
//
// state  | meaning
// S_IDLE | first cycle after reset, no request yet
// S_REQ  | request outstanding at req_addr, waiting for ack
// S_HELD | acked instruction parked in held_instr while decode stalls

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module fetch_top #(
  parameter logic [`ADDR_SIZE-1:0]  RESET_PC  = 32'h00001000,
  parameter logic [`INSTR_SIZE-1:0] NOP_INSTR = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hazard_stall,
  input  logic                   is_jump,
  input  logic [`ADDR_SIZE-1:0]  jump_addr,
  input  logic                   branch_taken,
  input  logic [`ADDR_SIZE-1:0]  branch_addr,
  output logic                   imem_req,
  output logic [`ADDR_SIZE-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [`INSTR_SIZE-1:0] imem_data,
  output logic [`ADDR_SIZE-1:0]  pc,
  output logic [`INSTR_SIZE-1:0] instruction
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_bubbles,
  output logic [31:0]            perf_squashed
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [`ADDR_SIZE-1:0]    pc_reg_q, pc_reg_d;
  logic [`ADDR_SIZE-1:0]    req_addr_q, req_addr_d;
  logic                     squash_q, squash_d;
  logic [`INSTR_SIZE-1:0]   held_q, held_d;
  logic [`ADDR_SIZE-1:0]    if_pc_d;
  logic [`INSTR_SIZE-1:0]   if_instr_d;

  logic                     redirect;
  logic [`ADDR_SIZE-1:0]    target;
  logic [`ADDR_SIZE-1:0]    seq_addr;
  logic                     fetch_evt;
  logic                     nop_evt;
  logic                     squash_evt;

  assign redirect = branch_taken | (is_jump & ~hazard_stall);
  assign target   = branch_taken ? branch_addr : jump_addr;
  assign seq_addr = req_addr_q + `ADDR_SIZE'(4);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d    = state_q;
    pc_reg_d   = pc_reg_q;
    req_addr_d = req_addr_q;
    squash_d   = squash_q;
    held_d     = held_q;
    if_pc_d    = pc;
    if_instr_d = instruction;
    fetch_evt  = 1'b0;
    nop_evt    = 1'b0;
    squash_evt = 1'b0;

    // A redirect always retargets the PC and bubbles IF/ID with pc unchanged.
    if (redirect) begin
      pc_reg_d   = target;
      if_instr_d = NOP_INSTR;
      nop_evt    = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        state_d    = S_REQ;
        req_addr_d = redirect ? target : pc_reg_q;
      end

      S_REQ: begin
        if (imem_ack && (squash_q || redirect)) begin
          // Stale or redirected data: drop it and restart at the current PC.
          squash_d   = 1'b0;
          squash_evt = 1'b1;
          req_addr_d = redirect ? target : pc_reg_q;
          if (!redirect && !hazard_stall) begin
            if_instr_d = NOP_INSTR;
            nop_evt    = 1'b1;
          end
        end else if (redirect) begin
          // The request cannot be withdrawn; remember to discard its data.
          squash_d = 1'b1;
        end else if (imem_ack) begin
          if (!hazard_stall) begin
            if_pc_d    = seq_addr;
            if_instr_d = imem_data;
            pc_reg_d   = seq_addr;
            req_addr_d = seq_addr;
            fetch_evt  = 1'b1;
          end else begin
            held_d  = imem_data;
            state_d = S_HELD;
          end
        end else if (!hazard_stall) begin
          if_instr_d = NOP_INSTR;
          nop_evt    = 1'b1;
        end
      end

      S_HELD: begin
        if (redirect) begin
          req_addr_d = target;
          squash_evt = 1'b1;
          state_d    = S_REQ;
        end else if (!hazard_stall) begin
          if_pc_d    = seq_addr;
          if_instr_d = held_q;
          pc_reg_d   = seq_addr;
          req_addr_d = seq_addr;
          fetch_evt  = 1'b1;
          state_d    = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and IF/ID registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg_q    <= RESET_PC;
      req_addr_q  <= RESET_PC;
      squash_q    <= 1'b0;
      held_q      <= NOP_INSTR;
      pc          <= '0;
      instruction <= NOP_INSTR;
    end else begin
      pc_reg_q    <= pc_reg_d;
      req_addr_q  <= req_addr_d;
      squash_q    <= squash_d;
      held_q      <= held_d;
      pc          <= if_pc_d;
      instruction <= if_instr_d;
    end
  end

  // Outputs depend on registered state only
  always_comb begin
    imem_req  = (state_q == S_REQ);
    imem_addr = req_addr_q;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_bubbles  <= '0;
      perf_squashed <= '0;
    end else begin
      if (fetch_evt)                perf_fetched  <= perf_fetched + 32'd1;
      if (nop_evt && !hazard_stall) perf_bubbles  <= perf_bubbles + 32'd1;
      if (squash_evt)               perf_squashed <= perf_squashed + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = &{1'b0, fetch_evt, nop_evt, squash_evt};
`endif

endmodule

// File: doc/fetch_top.md
Name: fetch_top

Overview:
- Instruction FETCH stage; producer side of the IF/ID boundary that decode_top consumes.
- Holds the PC and issues instruction-memory reads over a req/ack handshake with variable latency.
- Delivers pc/instruction into the IF/ID registers and honours decode's hazard_stall, decode's jump redirect (is_jump/jump_addr) and the M-stage branch redirect.
- Inserts NOP bubbles when no valid instruction is available.

Parameters:
- RESET_PC, 32'h00001000, first fetch address after reset
- NOP_INSTR, 32'h00000000, encoding loaded into IF/ID as a bubble

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- hazard_stall  input  1  decode stall; hold IF/ID and PC
- is_jump  input  1  decode: instruction in IF/ID is a jump
- jump_addr  input  `ADDR_SIZE  decode: jump target
- branch_taken  input  1  M stage: branch resolved taken
- branch_addr  input  `ADDR_SIZE  M stage: branch target
- imem_req  output  1  memory read request
- imem_addr  output  `ADDR_SIZE  memory read address
- imem_ack  input  1  memory data valid, one-cycle pulse
- imem_data  input  `INSTR_SIZE  memory read data
- pc  output  `ADDR_SIZE  IF/ID: fetched instruction address + 4
- instruction  output  `INSTR_SIZE  IF/ID: fetched instruction or NOP_INSTR

Behaviour:
- Reset values:
  - state=S_IDLE; pc_reg=RESET_PC; req_addr=RESET_PC
  - pc=0; instruction=NOP_INSTR; imem_req=0; squash=0; held buffer empty
- Handshake:
  - imem_req and imem_addr are driven from registered state only.
  - While imem_req=1, imem_addr is stable (=req_addr) until the cycle imem_ack=1.
  - Ack may arrive in the same cycle as req (zero-wait), or later.
  - A request cannot be withdrawn before its ack.
- Redirect: branch_taken > (is_jump && !hazard_stall) > sequential.
  - branch_taken acts even during hazard_stall.
  - Any redirect cycle: pc_reg <= target; IF/ID <= {pc unchanged, NOP_INSTR}; any instruction acked or held this cycle is discarded.
- FSM:
  - S_IDLE: imem_req=0.
    - Next cycle -> S_REQ with req_addr=pc_reg.
  - S_REQ: imem_req=1.
    - Redirect while no ack: squash<=1; stay S_REQ; req_addr unchanged.
    - Ack with squash=1, or ack in a redirect cycle: drop data; squash<=0; req_addr<=new pc_reg; stay S_REQ.
    - Ack, no squash, !hazard_stall: IF/ID <= {req_addr+4, imem_data}; pc_reg, req_addr <= req_addr+4; stay S_REQ. Sustains 1 instr/cycle with zero-wait memory.
    - Ack, no squash, hazard_stall: held_instr<=imem_data; -> S_HELD.
    - No ack, !hazard_stall: IF/ID <= {pc unchanged, NOP_INSTR} (bubble).
  - S_HELD: imem_req=0.
    - Redirect: drop held; req_addr<=target; -> S_REQ.
    - Else !hazard_stall: IF/ID <= {req_addr+4, held_instr}; pc_reg, req_addr <= req_addr+4; -> S_REQ.
    - Else hold.
- hazard_stall=1 without redirect: IF/ID and pc_reg hold their values.
- PC arithmetic: modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
- Reset asserted mid-request: all state returns to reset values immediately; a late ack while in S_IDLE is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] (instructions delivered to IF/ID), perf_bubbles[31:0] (NOP cycles with !hazard_stall) and perf_squashed[31:0] (acks discarded).
  - All counters reset to 0 and wrap silently.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Zero-wait memory with ack=req, data=addr, from reset -> cycles after S_IDLE deliver pc=1004,1008,100C with instructions 1000,1004,1008 back-to-back.
- Memory latency 3 cycles -> each instruction followed by 2 NOP bubbles; imem_addr stable throughout each request.
- hazard_stall=1 for 4 cycles with ack during stall -> IF/ID frozen, imem_req=0 in S_HELD; held instruction delivered the cycle after the stall drops, no loss or duplication.
- Jump in IF/ID, is_jump=1, jump_addr=2000 while a request for 1010 is outstanding -> 1010 data discarded on ack, next request addr=2000, IF/ID=NOP meanwhile.
- branch_taken=1, branch_addr=3000 together with is_jump=1 and hazard_stall=1 -> branch wins, next fetch 3000, IF/ID=NOP.
- Reset asserted while waiting for ack -> outputs return to reset values immediately; first request after release is RESET_PC.
